// File: rtl/aclk_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aclk_pkg
//  Description : Shared types and constants for the alarm-clock keypad
//                controller: FSM state type, keypad code width, the NOKEY
//                code and a digit classifier.
//  Revision    : 1.0 - initial release
// ============================================================================
package aclk_pkg;

    localparam int KEY_WIDTH = 4;

    // Code driven by the keypad scanner when nothing is pressed.
    localparam logic [KEY_WIDTH-1:0] NOKEY = 4'hA;

    typedef enum logic [2:0] {
        SHOW_TIME  = 3'd0,
        KEY_STORED = 3'd1,
        KEY_WAITED = 3'd2,
        KEY_ENTRY  = 3'd3,
        SHOW_ALARM = 3'd4
    } state_t;

    // Only 0..9 are digits; NOKEY and the unused codes B..F all read as
    // "no key pressed".
    function automatic logic is_digit(input logic [KEY_WIDTH-1:0] code);
        return (code <= 4'd9);
    endfunction

endpackage
`default_nettype wire

// File: rtl/aclk_key_timeout.sv
`default_nettype none
// ============================================================================
//  Module      : aclk_key_timeout
//  Description : Key-entry inactivity timer. Counts one-second ticks while
//                enabled and flags expiry on the tick that completes
//                TIMEOUT_SEC seconds. The count saturates rather than wraps.
//  Ports       : clk     - system clock
//                reset   - synchronous, active-low reset
//                clear   - restart the count from zero (wins over tick)
//                tick    - single-cycle one-second strobe
//                enable  - count only while high
//                expired - combinational; high on the expiring tick
//  Revision    : 1.0 - initial release
// ============================================================================
module aclk_key_timeout #(
    parameter int TIMEOUT_SEC = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic tick,
    input  logic enable,
    output logic expired
);

    localparam logic [3:0] c_last = 4'(TIMEOUT_SEC - 1);

    logic [3:0] r_count;
    logic       w_at_last;

    assign w_at_last = (r_count == c_last);
    assign expired   = enable && tick && w_at_last;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= 4'd0;
        end else if (clear) begin
            r_count <= 4'd0;
        end else if (enable && tick && !w_at_last) begin
            r_count <= r_count + 4'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/aclk_controller.sv
`default_nettype none
// ============================================================================
//  Module      : aclk_controller
//  Description : Alarm-clock keypad controller. Shifts keyed digits into the
//                new-time display, loads them into the clock or alarm
//                register on time_button / alarm_button, and shows the alarm
//                time while alarm_button is held.
//  Config      : define ACLK_CTRL_TIMEOUT_EN to abandon key entry after
//                TIMEOUT_SEC seconds without activity; otherwise entry waits
//                indefinitely and one_second is ignored.
//  Ports       : clk, reset (sync, active-low), one_second (tick),
//                key[3:0] (keypad code), alarm_button, time_button (levels)
//                -> load_new_a, load_new_c, reset_count, shift (pulses),
//                   show_new_time, show_a (display-select levels)
//  Revision    : 1.0 - initial release
// ============================================================================
module aclk_controller
    import aclk_pkg::*;
#(
    parameter int TIMEOUT_SEC = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 one_second,
    input  logic [KEY_WIDTH-1:0] key,
    input  logic                 alarm_button,
    input  logic                 time_button,
    output logic                 load_new_a,
    output logic                 load_new_c,
    output logic                 reset_count,
    output logic                 shift,
    output logic                 show_new_time,
    output logic                 show_a
);

    state_t r_state;
    state_t w_next;
    logic   w_digit;
    logic   w_expired;
    logic   w_load_a;
    logic   w_load_c;

    logic   r_load_a;
    logic   r_load_c;
    logic   r_shift;
    logic   r_show_new_time;
    logic   r_show_a;

    assign w_digit = is_digit(key);

`ifdef ACLK_CTRL_TIMEOUT_EN
    // Clearing while in KEY_STORED restarts the count for every digit, and
    // also discards a tick that landed on the edge leaving KEY_ENTRY.
    aclk_key_timeout #(
        .TIMEOUT_SEC (TIMEOUT_SEC)
    ) u_key_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (r_state == KEY_STORED),
        .tick    (one_second),
        .enable  ((r_state == KEY_WAITED) || (r_state == KEY_ENTRY)),
        .expired (w_expired)
    );
`else
    logic w_unused_tick;
    assign w_unused_tick = one_second ^ (TIMEOUT_SEC > 15);
    assign w_expired     = 1'b0;
`endif

    always_comb begin
        w_next   = r_state;
        w_load_a = 1'b0;
        w_load_c = 1'b0;
        case (r_state)
            SHOW_TIME: begin
                if (alarm_button)  w_next = SHOW_ALARM;
                else if (w_digit)  w_next = KEY_STORED;
            end
            SHOW_ALARM: begin
                if (!alarm_button) w_next = SHOW_TIME;
            end
            KEY_STORED: begin
                w_next = KEY_WAITED;
            end
            KEY_WAITED: begin
                // A held digit never re-shifts; wait for release.
                if (!w_digit)       w_next = KEY_ENTRY;
                else if (w_expired) w_next = SHOW_TIME;
            end
            KEY_ENTRY: begin
                if (time_button) begin
                    w_next   = SHOW_TIME;
                    w_load_c = 1'b1;
                end else if (alarm_button) begin
                    w_next   = SHOW_TIME;
                    w_load_a = 1'b1;
                end else if (w_digit) begin
                    w_next   = KEY_STORED;
                end else if (w_expired) begin
                    w_next   = SHOW_TIME;
                end
            end
            default: w_next = SHOW_TIME;
        endcase
    end

    // Level outputs are decoded from the next state so they are registered
    // yet line up with the state they describe.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state         <= SHOW_TIME;
            r_load_a        <= 1'b0;
            r_load_c        <= 1'b0;
            r_shift         <= 1'b0;
            r_show_new_time <= 1'b0;
            r_show_a        <= 1'b0;
        end else begin
            r_state         <= w_next;
            r_load_a        <= w_load_a;
            r_load_c        <= w_load_c;
            r_shift         <= (w_next == KEY_STORED);
            r_show_new_time <= (w_next == KEY_STORED) || (w_next == KEY_WAITED) ||
                               (w_next == KEY_ENTRY);
            r_show_a        <= (w_next == SHOW_ALARM);
        end
    end

    assign load_new_a    = r_load_a;
    assign load_new_c    = r_load_c;
    assign reset_count   = r_load_c;
    assign shift         = r_shift;
    assign show_new_time = r_show_new_time;
    assign show_a        = r_show_a;

endmodule
`default_nettype wire
